// File: rtl/prod_acc_pkg.sv
// Shared types and constants for the product accumulator stage.
// The accumulator consumes products from the 4x4 array multiplier.
package prod_acc_pkg;

  localparam int unsigned PROD_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 16;
  localparam int unsigned LEN_DEF    = 4;

  localparam logic [ACC_W_DEF-1:0] SAT_MAX = '1;

  // The count register must be able to hold LEN itself, not just LEN-1.
  function automatic int unsigned cnt_w(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/sat_adder.sv
// Unsigned adder that clamps to all-ones and reports when the true sum did not fit.
module sat_adder #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[W];
    sum  = full[W] ? '1 : full[W-1:0];
  end

endmodule

// File: rtl/prod_accumulator.sv
// Accumulates up to LEN multiplier products per frame into a saturating sum and
// presents each frame result on a registered valid/ready output.
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter  int unsigned PROD_W = PROD_W_DEF,
  parameter  int unsigned ACC_W  = ACC_W_DEF,
  parameter  int unsigned LEN    = LEN_DEF,
  localparam int unsigned CNT_W  = cnt_w(LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic [CNT_W-1:0]   cnt_inc;

  sat_adder #(.W(ACC_W)) u_sat_adder (
    .a   (acc_q),
    .b   (ACC_W'(in_prod)),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
          if (cnt_inc == CNT_W'(LEN) || in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        // Clearing on the output transfer keeps the next frame from seeing stale state.
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed and random checks of prod_accumulator: default instance plus a
// narrow-accumulator instance (ACC_W=10, LEN=5) for saturation.
module tb_prod_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_prod;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic [2:0]  out_count;

  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [9:0]  s_out_sum;
  logic [2:0]  s_out_count;

  int checks = 0;
  int errors = 0;
  bit use_s  = 1'b0;

  always #5 clk = ~clk;

  prod_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  prod_accumulator #(.PROD_W(8), .ACC_W(10), .LEN(5)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_sum(s_out_sum), .out_count(s_out_count), .out_ovf(s_out_ovf)
  );

  function automatic logic cur_ready();
    return use_s ? s_in_ready : in_ready;
  endfunction
  function automatic logic cur_valid();
    return use_s ? s_out_valid : out_valid;
  endfunction
  function automatic logic [31:0] cur_sum();
    return use_s ? 32'(s_out_sum) : 32'(out_sum);
  endfunction
  function automatic logic [31:0] cur_count();
    return use_s ? 32'(s_out_count) : 32'(out_count);
  endfunction
  function automatic logic cur_ovf();
    return use_s ? s_out_ovf : out_ovf;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] p, input logic last);
    int g;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    g = 0;
    while (!cur_ready() && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) fail_now("push_timeout");
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take(input string name, input logic [31:0] es, input logic [31:0] ec,
                      input logic [31:0] eo);
    int g;
    out_ready = 1'b1;
    g = 0;
    while (!cur_valid() && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) fail_now({name, "_valid_timeout"});
    chk({name, "_sum"},   cur_sum(),   es);
    chk({name, "_count"}, cur_count(), ec);
    chk({name, "_ovf"},   32'(cur_ovf()), eo);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_ready_after"}, 32'(cur_ready()), 1);
    chk({name, "_valid_after"}, 32'(cur_valid()), 0);
  endtask

  typedef struct {
    logic [7:0] p[4];
    int         n;
    int         last_at;
    int         es;
    int         ec;
    int         eo;
  } vec_t;

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int n, input int last_at, input int es, input int ec,
                              input int eo);
    vec_t v;
    v.p[0] = 8'(a); v.p[1] = 8'(b); v.p[2] = 8'(c); v.p[3] = 8'(d);
    v.n = n; v.last_at = last_at; v.es = es; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  typedef struct {
    int sum;
    int cnt;
    int ovf;
  } frame_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vt[6];
    frame_t q[$];
    frame_t f;
    int     sent, cyc, m_acc, m_cnt, m_ovf;
    bit     in_x, out_x;

    vt[0] = mk(10, 20, 30, 40, 4, 0, 100, 4, 0);
    vt[1] = mk(225, 225, 0, 0, 2, 2, 450, 2, 0);
    vt[2] = mk(0, 0, 0, 0, 3, 3, 0, 3, 0);
    vt[3] = mk(5, 0, 0, 0, 1, 1, 5, 1, 0);
    vt[4] = mk(1, 2, 3, 4, 4, 4, 10, 4, 0);
    vt[5] = mk(255, 255, 255, 255, 4, 0, 1020, 4, 0);

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum",   32'(out_sum),   0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_ovf",   32'(out_ovf),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven frames on the default instance
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vt[i].n - 1; k++)
        push(vt[i].p[k], (vt[i].last_at == k + 1));
      chk($sformatf("v%0d_pre_valid", i), 32'(out_valid), 0);
      push(vt[i].p[vt[i].n-1], (vt[i].last_at == vt[i].n));
      chk($sformatf("v%0d_lat_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d_hold_ready", i), 32'(in_ready), 0);
      take($sformatf("v%0d", i), vt[i].es, vt[i].ec, vt[i].eo);
    end

    // Backpressure: result held while producer keeps offering the next product
    push(7, 0); push(8, 0); push(9, 0); push(10, 0);
    in_valid = 1'b1; in_prod = 8'd50; in_last = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("bp_in_ready",  32'(in_ready),  0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_sum",   32'(out_sum),   34);
      chk("bp_out_count", 32'(out_count), 4);
    end
    take("bp", 34, 4, 0);
    push(50, 0); push(60, 0); push(70, 0); push(80, 0);
    take("bp_next", 260, 4, 0);

    // Asynchronous reset mid-frame
    push(3, 0); push(4, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_in_ready",  32'(in_ready),  1);
    chk("amid_out_valid", 32'(out_valid), 0);
    chk("amid_out_sum",   32'(out_sum),   0);
    chk("amid_out_count", 32'(out_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push(1, 0); push(1, 0); push(1, 0); push(1, 0);
    take("arst_next", 4, 4, 0);

    // Saturation on the narrow instance
    do_reset();
    use_s = 1'b1;
    repeat (5) push(225, 0);
    take("sat", 1023, 5, 1);
    push(1, 1);
    take("sat_next", 1, 1, 0);
    use_s = 1'b0;
    do_reset();

    // Random stream with transaction-level scoreboard
    sent = 0; cyc = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
    while (cyc < 20000 && (sent < 1000 || q.size() != 0 || in_valid)) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_prod  = 8'($urandom_range(0, 255));
        in_last  = ($urandom_range(0, 4) == 0);
      end
      out_ready = 1'($urandom_range(0, 1));
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        if (q.size() == 0) fail_now("rnd_unexpected_output");
        else begin
          f = q.pop_front();
          chk("rnd_sum",   32'(out_sum),   f.sum);
          chk("rnd_count", 32'(out_count), f.cnt);
          chk("rnd_ovf",   32'(out_ovf),   f.ovf);
        end
      end
      if (in_x) begin
        sent++;
        m_acc = m_acc + int'(in_prod);
        if (m_acc > 65535) begin m_acc = 65535; m_ovf = 1; end
        m_cnt++;
        if (m_cnt == 4 || in_last) begin
          q.push_back('{m_acc, m_cnt, m_ovf});
          m_acc = 0; m_cnt = 0; m_ovf = 0;
        end
      end
      @(negedge clk);
      cyc++;
      if (in_x) begin in_valid = 1'b0; in_last = 1'b0; end
    end
    if (sent < 1000 || q.size() != 0) fail_now("rnd_drain");
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
